// File: rtl/spi_reg_writer.sv
// SPI mode-0 slave that turns ADDR_W+DATA_W bit host frames into one-clk register writes.
// Optional macro ADDR_CHECK_EN: reject well-formed frames whose address is >= NUM_REGS.
module spi_reg_writer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  output logic              frame_err,
  output logic              busy
);

  localparam int FRAME_LEN = ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, cs_rise;
  logic [FRAME_LEN-1:0]   shreg;
  logic [CNT_W-1:0]       cnt;
  logic                   frame_ok, addr_ok, we_nxt, ferr_nxt;

  // Synchronizers reset to 0 so a frame still low on cs_n after reset is never mistaken for idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_rise   = cs_s & ~cs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_IDLE;
    else        state <= state_nxt;
  end

  // IDLE starts on cs_n low level, which also catches a fall that landed during COMMIT.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (cs_s)    state_nxt = IDLE;
      IDLE:      if (!cs_s)   state_nxt = SHIFT;
      SHIFT:     if (cs_rise) state_nxt = COMMIT;
      COMMIT:                 state_nxt = IDLE;
      default:                state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == IDLE && !cs_s) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == SHIFT && sclk_rise) begin
      shreg <= {shreg[FRAME_LEN-2:0], mosi_s};
      if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
    end
  end

  assign frame_ok = (cnt == CNT_FULL);

`ifdef ADDR_CHECK_EN
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
  assign addr_ok = ({1'b0, shreg[FRAME_LEN-1:DATA_W]} < NUM_REGS_W);
`else
  assign addr_ok = 1'b1;
`endif

  assign we_nxt   = (state == COMMIT) && frame_ok && addr_ok;
  assign ferr_nxt = (state == COMMIT) && !(frame_ok && addr_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we        <= 1'b0;
      frame_err <= 1'b0;
      addr      <= '0;
      data_in   <= '0;
    end else begin
      we        <= we_nxt;
      frame_err <= ferr_nxt;
      if (we_nxt) begin
        addr    <= shreg[FRAME_LEN-1:DATA_W];
        data_in <= shreg[DATA_W-1:0];
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: clk 100 MHz, sclk 8x slower, write/error pulses counted by a monitor.
module tb_spi_reg_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic       we, frame_err, busy;
  logic [7:0] addr, data_in;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  logic [7:0] log_a [0:31];
  logic [7:0] log_d [0:31];
  int w0, f0;

  spi_reg_writer dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .we(we), .addr(addr), .data_in(data_in),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        if (we_cnt < 32) begin
          log_a[we_cnt] = addr;
          log_d[we_cnt] = data_in;
        end
        we_cnt++;
      end
      if (frame_err) ferr_cnt++;
      if (we && frame_err) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    spi_cs_n = 1'b0;
    #40;
  endtask

  task automatic shift_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = val[i];
      #40 spi_sclk = 1'b1;
      #40 spi_sclk = 1'b0;
    end
  endtask

  task automatic end_frame(input int gap_ns);
    #40 spi_cs_n = 1'b1;
    #(gap_ns);
  endtask

  task automatic send(input logic [31:0] val, input int n);
    start_frame();
    shift_bits(val, n);
    end_frame(120);
  endtask

  initial begin
    rst_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    #30;
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data_in, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    #100;

    // 1: valid frame 0x037F
    w0 = we_cnt; f0 = ferr_cnt;
    start_frame();
    check("t1_busy_hi", busy, 1);
    shift_bits(32'h037F, 16);
    end_frame(120);
    check("t1_busy_lo", busy, 0);
    check("t1_we_cnt", we_cnt - w0, 1);
    check("t1_ferr_cnt", ferr_cnt - f0, 0);
    check("t1_log_addr", log_a[w0], 8'h03);
    check("t1_log_data", log_d[w0], 8'h7F);
    check("t1_addr", addr, 8'h03);
    check("t1_data", data_in, 8'h7F);

    // 2: short (15) and long (17) frames
    w0 = we_cnt; f0 = ferr_cnt;
    send(32'h1234, 15);
    send(32'h1ABCD, 17);
    check("t2_we_cnt", we_cnt - w0, 0);
    check("t2_ferr_cnt", ferr_cnt - f0, 2);
    check("t2_addr", addr, 8'h03);
    check("t2_data", data_in, 8'h7F);

    // 3: address 0x0C is outside the 10-register map
    w0 = we_cnt; f0 = ferr_cnt;
    send(32'h0C55, 16);
`ifdef ADDR_CHECK_EN
    check("t3_we_cnt", we_cnt - w0, 0);
    check("t3_ferr_cnt", ferr_cnt - f0, 1);
    check("t3_addr", addr, 8'h03);
    check("t3_data", data_in, 8'h7F);
`else
    check("t3_we_cnt", we_cnt - w0, 1);
    check("t3_ferr_cnt", ferr_cnt - f0, 0);
    check("t3_addr", addr, 8'h0C);
    check("t3_data", data_in, 8'h55);
`endif

    // 4: reset in the middle of a frame, tail discarded
    w0 = we_cnt; f0 = ferr_cnt;
    start_frame();
    shift_bits(32'h02, 8);
    rst_n = 1'b0;
    #30;
    check("t4_rst_addr", addr, 0);
    check("t4_rst_data", data_in, 0);
    check("t4_rst_busy", busy, 0);
    rst_n = 1'b1;
    #40;
    shift_bits(32'h01, 8);
    end_frame(120);
    check("t4_tail_we", we_cnt - w0, 0);
    check("t4_tail_ferr", ferr_cnt - f0, 0);
    send(32'h0201, 16);
    check("t4_we_cnt", we_cnt - w0, 1);
    check("t4_addr", addr, 8'h02);
    check("t4_data", data_in, 8'h01);

    // 5: back-to-back frames with a 4-clk cs_n gap
    w0 = we_cnt; f0 = ferr_cnt;
    start_frame();
    shift_bits(32'h0011, 16);
    end_frame(40);
    start_frame();
    shift_bits(32'h0922, 16);
    end_frame(120);
    check("t5_we_cnt", we_cnt - w0, 2);
    check("t5_ferr_cnt", ferr_cnt - f0, 0);
    check("t5_a0", log_a[w0], 8'h00);
    check("t5_d0", log_d[w0], 8'h11);
    check("t5_a1", log_a[w0+1], 8'h09);
    check("t5_d1", log_d[w0+1], 8'h22);

    // 6: sclk with cs_n high, then empty cs_n pulses
    w0 = we_cnt; f0 = ferr_cnt;
    for (int i = 0; i < 8; i++) begin
      spi_mosi = i[0];
      #40 spi_sclk = 1'b1;
      #40 spi_sclk = 1'b0;
    end
    #80;
    check("t6_sclk_we", we_cnt - w0, 0);
    check("t6_sclk_ferr", ferr_cnt - f0, 0);
    for (int i = 0; i < 3; i++) begin
      spi_cs_n = 1'b0;
      #40 spi_cs_n = 1'b1;
      #80;
    end
    #40;
    check("t6_pulse_we", we_cnt - w0, 0);
    check("t6_pulse_ferr", ferr_cnt - f0, 3);
    check("t6_addr", addr, 8'h09);

    check("we_ferr_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
